if_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the RV32I core. Holds the program counter, drives the instruction-memory address, and latches the fetched word and its PC into the IF/ID register. The immediate generator and the register-file read logic decode that register. Honours load-use stalls from the hazard unit and branch redirects/flushes from EX.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pc_reg.sv | 26 ++
 rtl/if_fetch_stage.sv | 80 ++++++++
 tb/tb_if_fetch_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, reset defaults, canonical NOP
// and the major opcodes used by the fetch stage, immediate generator and decoder.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    // Clear the byte-offset bits so an address lands on a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: asynchronous reset to RESET_PC, loads d when load
// is high and holds its value otherwise.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    // PC storage with asynchronous reset and load enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. The PC addresses a
// combinational ROM; the returned word and its PC are latched into IF/ID one
// cycle later. Redirects outrank stalls (the stalled ID slot is wrong-path),
// and flushes outrank stalls in IF/ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic        pc_load_s;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load_s),
        .d     (next_pc_s),
        .q     (pc_r)
    );

    assign imem_addr = pc_r;

    // Next-PC selection: redirect, then stall hold, then sequential advance
    always_comb begin
        next_pc_s = pc_r;
        pc_load_s = 1'b0;
        if (pc_src) begin
            next_pc_s = riscv_pkg::word_align(branch_target);
            pc_load_s = 1'b1;
        end else if (stall) begin
            next_pc_s = pc_r;
            pc_load_s = 1'b0;
        end else begin
            next_pc_s = pc_r + 32'd4;
            pc_load_s = 1'b1;
        end
    end

    // IF/ID register and valid-fetch counter; flush squashes even while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else if (flush) begin
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            fetch_count <= fetch_count;
        end else if (stall) begin
            if_id_pc    <= if_id_pc;
            if_id_instr <= if_id_instr;
            if_id_valid <= if_id_valid;
            fetch_count <= fetch_count;
        end else begin
            if_id_pc    <= pc_r;
            if_id_instr <= imem_data;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized
// control traffic compared against a cycle-level behavioural model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, pc_src;
    logic [31:0] branch_target, imem_addr, imem_data;
    logic [31:0] if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid;
    logic [31:0] rom_key;

    // second instance for the wrap-around reset vector
    logic        w_reset, w_stall, w_flush, w_pc_src;
    logic [31:0] w_branch_target, w_imem_addr, w_imem_data;
    logic [31:0] w_if_id_pc, w_if_id_instr, w_fetch_count;
    logic        w_if_id_valid;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    assign imem_data   = imem_addr ^ rom_key;
    assign w_imem_data = w_imem_addr;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_count(fetch_count)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(w_reset), .stall(w_stall), .flush(w_flush), .pc_src(w_pc_src),
        .branch_target(w_branch_target), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .if_id_pc(w_if_id_pc), .if_id_instr(w_if_id_instr), .if_id_valid(w_if_id_valid),
        .fetch_count(w_fetch_count)
    );

    wire [128:0] dut_vec = {imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count};

    function automatic logic [128:0] model_vec();
        return {m_pc, m_ifpc, m_instr, m_valid, m_cnt};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    // Advance one edge; the model applies the fetch rules to the current inputs.
    task automatic tick();
        logic [31:0] n_pc;
        if (pc_src)     n_pc = (branch_target / 32'd4) * 32'd4;
        else if (stall) n_pc = m_pc;
        else            n_pc = m_pc + 32'd4;
        if (flush) begin
            m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0;
        end else if (!stall) begin
            m_ifpc = m_pc; m_instr = m_pc ^ rom_key; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        m_pc = n_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
        branch_target = 32'h0; rom_key = 32'h0;
        @(posedge clk); #1;
        tests++;
        if (dut_vec !== {32'h0, 32'h0, NOP, 1'b0, 32'h0}) begin
            fails++; $display("FAIL reset_values got=%h want=%h", dut_vec, {32'h0, 32'h0, NOP, 1'b0, 32'h0});
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL free_run[%0d] got=%h want=%h", i, dut_vec, model_vec());
            end
        end
        tests++;
        if ({if_id_pc, if_id_instr, if_id_valid, fetch_count} !== {32'h8, 32'h8, 1'b1, 32'd3}) begin
            fails++; $display("FAIL free_run_3 got pc=%h instr=%h v=%b cnt=%0d want 8/8/1/3",
                              if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (imem_addr !== 32'hC || if_id_pc !== 32'h8 || fetch_count !== 32'd3) begin
                fails++; $display("FAIL stall_hold[%0d] got addr=%h pc=%h cnt=%0d want C/8/3",
                                  i, imem_addr, if_id_pc, fetch_count);
            end
        end
        stall = 1'b0;
        tick();
        tests++;
        if (if_id_pc !== 32'hC || fetch_count !== 32'd4 || dut_vec !== model_vec()) begin
            fails++; $display("FAIL stall_release got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_branch();
        int guard = 0;
        while (m_pc != 32'h20 && guard < 20) begin
            tick();
            guard++;
        end
        tests++;
        if (imem_addr !== 32'h20) begin
            fails++; $display("FAIL reach_0x20 got=%h want=00000020", imem_addr);
        end
        pc_src = 1'b1; flush = 1'b1; branch_target = 32'h103;
        tick();
        pc_src = 1'b0; flush = 1'b0;
        tests++;
        if (imem_addr !== 32'h100 || if_id_instr !== NOP || if_id_valid !== 1'b0) begin
            fails++; $display("FAIL branch_squash got addr=%h instr=%h v=%b want 100/13/0",
                              imem_addr, if_id_instr, if_id_valid);
        end
        tick();
        tests++;
        if (if_id_pc !== 32'h100 || if_id_instr !== 32'h100 || dut_vec !== model_vec()) begin
            fails++; $display("FAIL branch_target got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_all_three();
        logic [31:0] cnt_before, tgt;
        cnt_before = fetch_count;
        tgt = $urandom;
        pc_src = 1'b1; flush = 1'b1; stall = 1'b1; branch_target = tgt;
        tick();
        pc_src = 1'b0; flush = 1'b0; stall = 1'b0;
        tests++;
        if (fetch_count !== cnt_before || if_id_valid !== 1'b0 ||
            imem_addr !== (tgt & 32'hFFFF_FFFC) || dut_vec !== model_vec()) begin
            fails++; $display("FAIL all_three got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        rom_key = $urandom;
        for (int i = 0; i < 300; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            pc_src        = ($urandom_range(0, 7) == 0);
            flush         = pc_src ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            branch_target = $urandom;
            tick();
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++; bad++;
                if (bad < 5) $display("FAIL random[%0d] got=%h want=%h", i, dut_vec, model_vec());
            end
        end
        stall = 1'b0; pc_src = 1'b0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (dut_vec !== {32'h0, 32'h0, NOP, 1'b0, 32'h0}) begin
            fails++; $display("FAIL async_reset got=%h want=%h", dut_vec, {32'h0, 32'h0, NOP, 1'b0, 32'h0});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rom_key = 32'h0;
        model_reset();
        tick();
        tests++;
        if (dut_vec !== model_vec() || fetch_count !== 32'd1) begin
            fails++; $display("FAIL after_reset got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        tests++;
        if (w_imem_addr !== 32'hFFFF_FFF8) begin
            fails++; $display("FAIL wrap_reset_pc got=%h want=fffffff8", w_imem_addr);
        end
        w_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (w_if_id_pc !== exp_pc[i] || w_if_id_instr !== exp_pc[i] || w_if_id_valid !== 1'b1) begin
                fails++; $display("FAIL wrap[%0d] got pc=%h instr=%h v=%b want %h",
                                  i, w_if_id_pc, w_if_id_instr, w_if_id_valid, exp_pc[i]);
            end
        end
        tests++;
        if (w_imem_addr !== 32'h4 || w_fetch_count !== 32'd3) begin
            fails++; $display("FAIL wrap_end got addr=%h cnt=%0d want 4/3", w_imem_addr, w_fetch_count);
        end
    endtask

    initial begin
        w_reset = 1'b1; w_stall = 1'b0; w_flush = 1'b0; w_pc_src = 1'b0;
        w_branch_target = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_all_three();
        test_random();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
